// File: rtl/ahb_sram_slave_param.sv
// AHB-Lite SRAM slave with pipelined address/data phases, byte lanes, wait states and ERROR response.
// Define AHB_SLV_PROT_EN to make word indices 0..PROT_WORDS-1 write-protected.
module ahb_sram_slave_param #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned PROT_WORDS  = 4
) (
    input  logic              i_hclk,
    input  logic              i_hreset,
    input  logic              i_hsel,
    input  logic [ADDR_W-1:0] i_haddr,
    input  logic [1:0]        i_htrans,
    input  logic              i_hwrite,
    input  logic [2:0]        i_hsize,
    input  logic [DATA_W-1:0] i_hwdata,
    input  logic              i_hready,
    output logic              o_hreadyout,
    output logic              o_hresp,
    output logic [DATA_W-1:0] o_hrdata,
    output logic              o_error
);

    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned LB = $clog2(NB);
    localparam int unsigned IW = $clog2(DEPTH);

`ifdef AHB_SLV_PROT_EN
    localparam bit ProtEn = 1'b1;
`else
    localparam bit ProtEn = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StData,
        StErr1,
        StErr2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_wait_cnt;
    logic [3:0]        w_wait_cnt_next;
    logic [IW-1:0]     r_idx;
    logic [LB-1:0]     r_off;
    logic [2:0]        r_size;
    logic              r_write;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_accept;
    logic [IW-1:0]     w_idx_in;
    logic [LB-1:0]     w_off_in;
    logic              w_size_bad;
    logic              w_misalign;
    logic              w_prot_hit;
    logic              w_illegal;
    logic              w_commit;
    logic [NB-1:0]     w_be;
    logic              w_unused;

    assign w_accept = i_hsel && i_hready && i_htrans[1];
    assign w_idx_in = i_haddr[IW+LB-1:LB];
    assign w_off_in = i_haddr[LB-1:0];
    assign w_unused = ^{i_haddr[ADDR_W-1:IW+LB], i_htrans[0]};

    // Legality is decided at address acceptance so the data phase only needs the verdict.
    always_comb begin
        w_size_bad = (i_hsize > 3'(LB));
        w_misalign = 1'b0;
        for (int b = 0; b < int'(LB); b++) begin
            if (i_haddr[b] && (b < int'(i_hsize))) begin
                w_misalign = 1'b1;
            end
        end
        w_prot_hit = ProtEn && i_hwrite && (32'(w_idx_in) < PROT_WORDS);
        w_illegal  = w_size_bad || w_misalign || w_prot_hit;
    end

    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_idx   <= '0;
            r_off   <= '0;
            r_size  <= '0;
            r_write <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= w_idx_in;
            r_off   <= w_off_in;
            r_size  <= i_hsize;
            r_write <= i_hwrite;
        end
    end

    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_state    <= StIdle;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        o_hreadyout     = 1'b1;
        o_hresp         = 1'b0;
        o_error         = 1'b0;
        case (r_state)
            StWait: begin
                o_hreadyout     = 1'b0;
                w_wait_cnt_next = r_wait_cnt - 4'd1;
                if (r_wait_cnt == 4'd1) begin
                    w_state_next = StData;
                end
            end
            StErr1: begin
                o_hreadyout  = 1'b0;
                o_hresp      = 1'b1;
                o_error      = 1'b1;
                w_state_next = StErr2;
            end
            StErr2: begin
                o_hresp = 1'b1;
            end
            default: begin
            end
        endcase
        // Every state that shows hreadyout=1 ends a phase and may take the next address.
        if (r_state == StIdle || r_state == StData || r_state == StErr2) begin
            w_state_next = StIdle;
            if (w_accept) begin
                if (w_illegal) begin
                    w_state_next = StErr1;
                end else if (WAIT_STATES == 0) begin
                    w_state_next = StData;
                end else begin
                    w_state_next    = StWait;
                    w_wait_cnt_next = 4'(WAIT_STATES);
                end
            end
        end
    end

    always_comb begin
        for (int b = 0; b < int'(NB); b++) begin
            w_be[b] = (b >= int'(r_off)) && (b < int'(r_off) + (1 << r_size));
        end
    end

    assign w_commit = (r_state == StData) && r_write;
    assign o_hrdata = ((r_state == StData) && !r_write) ? r_mem[r_idx] : '0;

    // Memory is deliberately not reset; a reset only blocks a commit in flight.
    always_ff @(posedge i_hclk) begin
        if (!i_hreset && w_commit) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (w_be[b]) begin
                    r_mem[r_idx][8*b +: 8] <= i_hwdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave_param.sv
// Directed bench: one zero-wait slave (a_*) and one three-wait slave (b_*), hready looped back.
module tb_ahb_sram_slave_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_hsel, b_hsel, a_hwrite, b_hwrite;
    logic [31:0] a_haddr, b_haddr, a_hwdata, b_hwdata;
    logic [1:0]  a_htrans, b_htrans;
    logic [2:0]  a_hsize, b_hsize;
    logic        a_hready, b_hready, a_hreadyout, b_hreadyout;
    logic        a_hresp, b_hresp, a_error, b_error;
    logic [31:0] a_hrdata, b_hrdata;
    int          checks = 0;
    int          failures = 0;

    assign a_hready = a_hreadyout;
    assign b_hready = b_hreadyout;

    always #5 clk = ~clk;

    ahb_sram_slave_param #(.WAIT_STATES(0)) u_dut0 (
        .i_hclk(clk), .i_hreset(rst), .i_hsel(a_hsel), .i_haddr(a_haddr), .i_htrans(a_htrans),
        .i_hwrite(a_hwrite), .i_hsize(a_hsize), .i_hwdata(a_hwdata), .i_hready(a_hready),
        .o_hreadyout(a_hreadyout), .o_hresp(a_hresp), .o_hrdata(a_hrdata), .o_error(a_error)
    );

    ahb_sram_slave_param #(.WAIT_STATES(3)) u_dut3 (
        .i_hclk(clk), .i_hreset(rst), .i_hsel(b_hsel), .i_haddr(b_haddr), .i_htrans(b_htrans),
        .i_hwrite(b_hwrite), .i_hsize(b_hsize), .i_hwdata(b_hwdata), .i_hready(b_hready),
        .o_hreadyout(b_hreadyout), .o_hresp(b_hresp), .o_hrdata(b_hrdata), .o_error(b_error)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic a_addr(input logic [31:0] addr, input logic wr, input logic [2:0] sz);
        a_hsel = 1'b1; a_htrans = 2'b10; a_haddr = addr; a_hwrite = wr; a_hsize = sz;
    endtask

    task automatic a_idle();
        a_hsel = 1'b0; a_htrans = 2'b00; a_haddr = '0; a_hwrite = 1'b0; a_hsize = 3'd2;
    endtask

    task automatic b_addr(input logic [31:0] addr, input logic wr, input logic [2:0] sz);
        b_hsel = 1'b1; b_htrans = 2'b10; b_haddr = addr; b_hwrite = wr; b_hsize = sz;
    endtask

    task automatic b_idle();
        b_hsel = 1'b0; b_htrans = 2'b00; b_haddr = '0; b_hwrite = 1'b0; b_hsize = 3'd2;
    endtask

    task automatic test_reset();
        rst = 1'b1; a_idle(); b_idle(); a_hwdata = '0; b_hwdata = '0;
        cyc(); cyc();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (a_hreadyout !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", a_hreadyout); end
        checks++; if (a_hresp !== 1'b0) begin failures++; $display("FAIL reset_hresp got=%b exp=0", a_hresp); end
        checks++; if (a_hrdata !== 32'h0) begin failures++; $display("FAIL reset_hrdata got=%h exp=0", a_hrdata); end
        checks++; if (a_error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", a_error); end
        checks++; if (b_hreadyout !== 1'b1) begin failures++; $display("FAIL reset_ready_ws3 got=%b exp=1", b_hreadyout); end
    endtask

    task automatic test_back_to_back();
        cyc(); a_addr(32'h40, 1'b1, 3'd2);
        cyc(); a_hwdata = 32'hDEADBEEF; a_addr(32'h40, 1'b0, 3'd2);
        @(negedge clk);
        checks++; if (a_hreadyout !== 1'b1) begin failures++; $display("FAIL b2b_wr_ready got=%b exp=1", a_hreadyout); end
        checks++; if (a_hresp !== 1'b0) begin failures++; $display("FAIL b2b_wr_hresp got=%b exp=0", a_hresp); end
        cyc(); a_idle();
        @(negedge clk);
        checks++; if (a_hrdata !== 32'hDEADBEEF) begin failures++; $display("FAIL b2b_rdata got=%h exp=deadbeef", a_hrdata); end
        checks++; if (a_hresp !== 1'b0) begin failures++; $display("FAIL b2b_rd_hresp got=%b exp=0", a_hresp); end
        cyc();
        @(negedge clk);
        checks++; if (a_hrdata !== 32'h0) begin failures++; $display("FAIL b2b_idle_rdata got=%h exp=0", a_hrdata); end
    endtask

    task automatic test_byte_lanes();
        cyc(); a_addr(32'h40, 1'b1, 3'd2);
        cyc(); a_hwdata = 32'h11223344; a_addr(32'h41, 1'b1, 3'd0);
        cyc(); a_hwdata = 32'hFFFFAAFF; a_addr(32'h40, 1'b0, 3'd2);
        cyc(); a_idle();
        @(negedge clk);
        checks++; if (a_hrdata !== 32'h1122AA44) begin failures++; $display("FAIL byte_write got=%h exp=1122aa44", a_hrdata); end
        cyc(); a_addr(32'h42, 1'b1, 3'd1);
        cyc(); a_hwdata = 32'hBEEF1234; a_addr(32'h40, 1'b0, 3'd2);
        cyc(); a_idle();
        @(negedge clk);
        checks++; if (a_hrdata !== 32'hBEEFAA44) begin failures++; $display("FAIL half_write got=%h exp=beefaa44", a_hrdata); end
    endtask

    task automatic test_error();
        cyc(); a_addr(32'h40, 1'b0, 3'd3);
        cyc(); a_idle();
        @(negedge clk);
        checks++; if (a_hresp !== 1'b1) begin failures++; $display("FAIL oversize_hresp got=%b exp=1", a_hresp); end
        checks++; if (a_hreadyout !== 1'b0) begin failures++; $display("FAIL oversize_ready got=%b exp=0", a_hreadyout); end
        cyc(); cyc();
        a_addr(32'h43, 1'b1, 3'd1);
        cyc(); a_idle(); a_hwdata = 32'h55555555;
        @(negedge clk);
        checks++; if (a_hresp !== 1'b1) begin failures++; $display("FAIL err1_hresp got=%b exp=1", a_hresp); end
        checks++; if (a_hreadyout !== 1'b0) begin failures++; $display("FAIL err1_ready got=%b exp=0", a_hreadyout); end
        checks++; if (a_error !== 1'b1) begin failures++; $display("FAIL err1_error got=%b exp=1", a_error); end
        checks++; if (a_hrdata !== 32'h0) begin failures++; $display("FAIL err1_rdata got=%h exp=0", a_hrdata); end
        cyc(); a_addr(32'h40, 1'b0, 3'd2);
        @(negedge clk);
        checks++; if (a_hresp !== 1'b1) begin failures++; $display("FAIL err2_hresp got=%b exp=1", a_hresp); end
        checks++; if (a_hreadyout !== 1'b1) begin failures++; $display("FAIL err2_ready got=%b exp=1", a_hreadyout); end
        checks++; if (a_error !== 1'b0) begin failures++; $display("FAIL err2_error got=%b exp=0", a_error); end
        cyc(); a_idle();
        @(negedge clk);
        checks++; if (a_hresp !== 1'b0) begin failures++; $display("FAIL err_after_hresp got=%b exp=0", a_hresp); end
        checks++; if (a_hrdata !== 32'hBEEFAA44) begin failures++; $display("FAIL err_mem_kept got=%h exp=beefaa44", a_hrdata); end
    endtask

    task automatic test_protect();
        logic prot_on;
`ifdef AHB_SLV_PROT_EN
        prot_on = 1'b1;
`else
        prot_on = 1'b0;
`endif
        cyc(); a_addr(32'h08, 1'b1, 3'd2);
        cyc(); a_idle(); a_hwdata = 32'hCAFEF00D;
        @(negedge clk);
        checks++; if (a_hresp !== prot_on) begin failures++; $display("FAIL prot_wr_hresp got=%b exp=%b", a_hresp, prot_on); end
        cyc(); cyc();
        a_addr(32'h08, 1'b0, 3'd2);
        cyc(); a_idle();
        @(negedge clk);
        checks++;
        if ((a_hrdata === 32'hCAFEF00D) === prot_on) begin
            failures++; $display("FAIL prot_rd_data got=%h written=cafef00d protected=%b", a_hrdata, prot_on);
        end
        cyc(); a_addr(32'h10, 1'b1, 3'd2);
        cyc(); a_hwdata = 32'h0BADC0DE; a_addr(32'h10, 1'b0, 3'd2);
        @(negedge clk);
        checks++; if (a_hresp !== 1'b0) begin failures++; $display("FAIL unprot_wr_hresp got=%b exp=0", a_hresp); end
        cyc(); a_idle();
        @(negedge clk);
        checks++; if (a_hrdata !== 32'h0BADC0DE) begin failures++; $display("FAIL unprot_rd got=%h exp=0badc0de", a_hrdata); end
    endtask

    task automatic test_wait_states();
        logic exp_rdy;
        cyc(); b_addr(32'h0C, 1'b1, 3'd2);
        cyc(); b_idle(); b_hwdata = 32'h600DCAFE;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp_rdy = (i == 3);
            checks++; if (b_hreadyout !== exp_rdy) begin failures++; $display("FAIL ws_wr_ready%0d got=%b exp=%b", i, b_hreadyout, exp_rdy); end
        end
        cyc(); b_addr(32'h0C, 1'b0, 3'd2);
        cyc(); b_idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp_rdy = (i == 3);
            checks++; if (b_hreadyout !== exp_rdy) begin failures++; $display("FAIL ws_rd_ready%0d got=%b exp=%b", i, b_hreadyout, exp_rdy); end
        end
        checks++; if (b_hrdata !== 32'h600DCAFE) begin failures++; $display("FAIL ws_rdata got=%h exp=600dcafe", b_hrdata); end
        @(negedge clk);
        checks++; if (b_hreadyout !== 1'b1) begin failures++; $display("FAIL ws_after_ready got=%b exp=1", b_hreadyout); end
        checks++; if (b_hrdata !== 32'h0) begin failures++; $display("FAIL ws_after_rdata got=%h exp=0", b_hrdata); end
    endtask

    task automatic test_reset_abort();
        cyc(); b_addr(32'h0C, 1'b1, 3'd2);
        cyc(); b_idle(); b_hwdata = 32'h12345678;
        @(negedge clk);
        checks++; if (b_hreadyout !== 1'b0) begin failures++; $display("FAIL abort_wait_ready got=%b exp=0", b_hreadyout); end
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0;
        @(negedge clk);
        checks++; if (b_hreadyout !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", b_hreadyout); end
        checks++; if (b_hresp !== 1'b0) begin failures++; $display("FAIL abort_hresp got=%b exp=0", b_hresp); end
        cyc(); b_addr(32'h0C, 1'b0, 3'd2);
        cyc(); b_idle();
        repeat (3) @(negedge clk);
        @(negedge clk);
        checks++; if (b_hreadyout !== 1'b1) begin failures++; $display("FAIL abort_rd_ready got=%b exp=1", b_hreadyout); end
        checks++; if (b_hrdata !== 32'h600DCAFE) begin failures++; $display("FAIL abort_mem_kept got=%h exp=600dcafe", b_hrdata); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_byte_lanes();
        test_error();
        test_protect();
        test_wait_states();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
